spi_reg_bank: RTL
=================

# spi_reg_bank

Parametrised SPI Mode-0 register bank: the next-generation SPI peripheral for the control plane. It oversamples SCLK/COPI/nCS in the system clock domain and decodes frames of one R/W bit, an address field and a data field. Writes commit atomically at frame end; optional readback returns register contents on CIPO. The flat register vector drives the output-enable, PWM-enable and duty-cycle logic downstream.

## Interface

- ADDR_W, default 7: address field width in bits.
- DATA_W, default 8: register and data field width in bits.
- NUM_REGS, default 5: implemented registers, addresses 0..NUM_REGS-1; must be ≤ 2^ADDR_W.
- RESET_VAL, default 0: reset value of every register (DATA_W bits).

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous.
- copi  in  1  controller-out data, asynchronous.
- ncs  in  1  active-low chip select, asynchronous.
- cipo  out  1  peripheral-out data.
- cipo_oe  out  1  high while synchronised ncs is low; pad tri-state enable.
- regs_out  out  NUM_REGS*DATA_W  flat register contents; register k at [k*DATA_W +: DATA_W].
- wr_strobe  out  1  one-cycle pulse when a register is updated.
- wr_addr  out  ADDR_W  address of the last committed write; valid with wr_strobe, held otherwise.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

## Operation

- Frame length F = 1 + ADDR_W + DATA_W bits, MSB first. Bit 0 of the frame is R/W: 1 = write, 0 = read. It is followed by the address, then the data.
- Each of sclk, copi and ncs passes through a 2-FF synchroniser plus one history FF. Edges are detected on the synchronised value versus the history FF.
- States: IDLE, SHIFT, COMMIT.
  - IDLE → SHIFT on ncs falling edge; bit counter cleared, shift register cleared.
  - SHIFT: on each sclk rising edge, shift in synchronised copi and increment the counter. The counter saturates at F+1.
  - SHIFT → COMMIT on ncs rising edge.
  - COMMIT (one cycle) → IDLE.
- In COMMIT, a write is applied only if all of the following hold: counter == F, R/W = 1, address < NUM_REGS. Applying a write updates the register and pulses wr_strobe.
- In COMMIT, frame_err pulses if counter ≠ F (short or over-length frame). Nothing is written.
- A write to address ≥ NUM_REGS, or any read, writes nothing and raises no error.
- Simultaneous sclk and ncs edges in one cycle: the ncs edge wins and the sclk edge is ignored.
- An ncs falling edge while in COMMIT is honoured on the next cycle and is not lost. The ncs synchroniser history guarantees this.
- Reset mid-frame: the frame is abandoned, state → IDLE, all registers → RESET_VAL.

## Timing

- Input-to-detect latency: 3 clk cycles from pin edge to internal edge pulse.
- sclk high and low phases must each be ≥ 4 clk cycles. The ncs setup and hold to the first and last sclk edge must each be ≥ 4 clk cycles.
- Write commit: regs_out and wr_strobe update on the clk edge that ends COMMIT, which is 4 clk cycles after the ncs pin rises.
- Read: on the sclk rising edge that samples the last address bit, the output shift register is loaded with reg[addr], or 0 if the address is out of range. cipo = that MSB on the next clk. Each subsequent synchronised sclk falling edge shifts the next bit out.
- cipo = 0 whenever not reading.
- Reset values: cipo=0, cipo_oe=0, wr_strobe=0, wr_addr=0, frame_err=0, regs_out=all RESET_VAL, state=IDLE.

## Configuration

- SPI_REG_READBACK_EN
  - Defined: read frames return data on cipo as described above.
  - Undefined: the output shift register and read path are not compiled; cipo is tied 0 and cipo_oe is tied 0. Read frames are still framed and counted: a correct-length read causes no write and no frame_err, and a wrong-length read pulses frame_err.

## Test plan

- Write, defaults: frame 1, addr 2, data 0xA5, sclk = clk/10 → regs_out[23:16]=0xA5, one wr_strobe with wr_addr=2, other registers unchanged.
- Out-of-range write: addr 5, data 0xFF → no wr_strobe, no frame_err, regs_out unchanged.
- Short frame: ncs rises after 12 bits of a write to addr 0 → frame_err pulses once, reg 0 unchanged. Over-length 17-bit frame → same.
- Readback (macro defined): write 0x3C to addr 4, then a read of addr 4 → cipo bits 0,0,1,1,1,1,0,0 on the last 8 sclk rising edges. Read of addr 9 → all zeros.
- Reset mid-frame: assert rst for 1 cycle after 8 bits of a write to addr 1 → state IDLE, all registers = RESET_VAL, no wr_strobe. The next full frame (addr 1, 0x11) commits normally.
- Parametrised build: ADDR_W=4, DATA_W=16, NUM_REGS=3. Write 0xBEEF to addr 2 → regs_out[47:32]=0xBEEF. A 21-bit frame is accepted; a 17-bit frame raises frame_err.

Source files
------------

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bank
// Description : SPI mode-0 register bank. SCLK/COPI/nCS are oversampled in the
//               clk domain. Each frame carries an R/W bit (1 = write), an
//               address and a data field, sent MSB first. A write commits
//               atomically at frame end. An optional read path returns
//               register contents on CIPO; it is compiled only when the
//               macro SPI_REG_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bank #(
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int c_frame_len = 1 + ADDR_W + DATA_W;
    localparam int c_cnt_w     = $clog2(c_frame_len + 2);

    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(c_frame_len);
    localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(c_frame_len + 1);
    localparam logic [ADDR_W:0]    c_num_regs = (ADDR_W + 1)'(NUM_REGS);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
    localparam logic [1:0] c_st_commit = 2'd2;

    // [0] first sync stage, [1] synchronised value, [2] history for edge detect
    logic [2:0] r_sclk_pipe;
    logic [2:0] r_ncs_pipe;
    // copi is only ever sampled as a level, so it needs no history stage
    logic [1:0] r_copi_pipe;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_frame_len-1:0]   r_shift;
    logic                     r_ncs_fall_pend;
    logic [DATA_W-1:0]        r_regs [NUM_REGS];

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_copi;
    logic w_frame_start;
    logic w_bit_take;
    logic w_bit_give;
    logic w_commit;

    logic              w_rw;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_addr_ok;
    logic              w_wr_en;

    // Synchronise the asynchronous pins; ncs idles high so reset it high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_pipe <= 3'b000;
            r_ncs_pipe  <= 3'b111;
            r_copi_pipe <= 2'b00;
        end else begin
            r_sclk_pipe <= {r_sclk_pipe[1:0], sclk};
            r_ncs_pipe  <= {r_ncs_pipe[1:0], ncs};
            r_copi_pipe <= {r_copi_pipe[0], copi};
        end
    end

    assign w_sclk_rise =  r_sclk_pipe[1] & ~r_sclk_pipe[2];
    assign w_sclk_fall = ~r_sclk_pipe[1] &  r_sclk_pipe[2];
    assign w_ncs_rise  =  r_ncs_pipe[1]  & ~r_ncs_pipe[2];
    assign w_ncs_fall  = ~r_ncs_pipe[1]  &  r_ncs_pipe[2];
    assign w_copi      =  r_copi_pipe[1];

    // Remember an ncs fall seen during COMMIT so the next frame still starts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ncs_fall_pend <= 1'b0;
        end else begin
            r_ncs_fall_pend <= (r_state == c_st_commit) && w_ncs_fall;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_ncs_fall || r_ncs_fall_pend) w_state_nxt = c_st_shift;
            c_st_shift:  if (w_ncs_rise) w_state_nxt = c_st_commit;
            c_st_commit: w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // State-decoded controls; an ncs edge masks a coincident sclk edge
    always_comb begin
        w_frame_start = (r_state == c_st_idle) && (w_ncs_fall || r_ncs_fall_pend);
        w_bit_take    = (r_state == c_st_shift) && w_sclk_rise && !w_ncs_rise;
        w_bit_give    = (r_state == c_st_shift) && w_sclk_fall && !w_ncs_rise;
        w_commit      = (r_state == c_st_commit);
    end

    // Input shift register and saturating bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_frame_start) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_bit_take) begin
            r_shift <= {r_shift[c_frame_len-2:0], w_copi};
            if (r_cnt != c_cnt_sat) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign w_rw      = r_shift[c_frame_len-1];
    assign w_addr    = r_shift[DATA_W +: ADDR_W];
    assign w_data    = r_shift[DATA_W-1:0];
    assign w_addr_ok = ({1'b0, w_addr} < c_num_regs);
    assign w_wr_en   = w_commit && (r_cnt == c_cnt_full) && w_rw && w_addr_ok;

    // Commit status pulses and the held address of the last write
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= w_wr_en;
            frame_err <= w_commit && (r_cnt != c_cnt_full);
            if (w_wr_en) begin
                wr_addr <= w_addr;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        // Register k takes the frame data when a valid write addresses it
        always_ff @(posedge clk) begin
            if (rst) begin
                r_regs[k] <= RESET_VAL;
            end else if (w_wr_en && (w_addr == ADDR_W'(k))) begin
                r_regs[k] <= w_data;
            end
        end
        assign regs_out[k*DATA_W +: DATA_W] = r_regs[k];
    end

`ifdef SPI_REG_READBACK_EN
    localparam logic [c_cnt_w-1:0] c_cnt_last_addr   = c_cnt_w'(ADDR_W);
    localparam logic [c_cnt_w-1:0] c_cnt_first_shift = c_cnt_w'(ADDR_W + 2);

    logic [ADDR_W:0]   w_hdr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_tx;
    logic              r_rd_active;

    // R/W bit and address as they stand once the last address bit arrives
    assign w_hdr     = {r_shift[ADDR_W-1:0], w_copi};
    assign w_rd_addr = w_hdr[ADDR_W-1:0];

    // Read mux; out-of-range addresses return zero
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rd_addr == ADDR_W'(k)) w_rd_data = r_regs[k];
        end
    end

    // Output shifter: loaded on the last address bit; the fall right after
    // the load is skipped so the MSB is still present at the next rise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx        <= '0;
            r_rd_active <= 1'b0;
        end else if (r_state != c_st_shift) begin
            r_tx        <= '0;
            r_rd_active <= 1'b0;
        end else if (w_bit_take && (r_cnt == c_cnt_last_addr)) begin
            r_tx        <= w_rd_data;
            r_rd_active <= ~w_hdr[ADDR_W];
        end else if (w_bit_give && (r_cnt >= c_cnt_first_shift)) begin
            r_tx <= {r_tx[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo    = r_rd_active & r_tx[DATA_W-1];
    assign cipo_oe = ~r_ncs_pipe[1];
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule
`default_nettype wire
